div_unit: RTL and testbench

Multi-cycle 32-bit integer divider for the execute stage, serving DIV and DIVU. It is the producer side of the divider stall handshake: the hazard unit holds E/F/D stalled while the E-stage ALU control is `DIV_CONTROL`/`DIVU_CONTROL` and `ready_o` is low. The block runs a radix-2 restoring divide, one quotient bit per cycle. It returns {remainder, quotient} for the HI/LO write.

---
 rtl/div_unit_pkg.sv | 17 +
 rtl/div_unit.sv | 88 ++++++++
 tb/tb_div_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared execute-stage defines for the divider
//   DIV_CONTROL / DIVU_CONTROL : ALU control codes that engage the divider stall
//   state_e                    : divider FSM state encodings
//   neg_if                     : conditional two's-complement negate
package div_unit_pkg;
  localparam logic [4:0] DIV_CONTROL  = 5'd20;
  localparam logic [4:0] DIVU_CONTROL = 5'd21;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_DIVZERO = 2'd2,
    S_DONE    = 2'd3
  } state_e;
  function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
    return n ? -v : v;
  endfunction
endpackage

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring 32-bit divider for DIV/DIVU
//   clk, rst            : clock, synchronous active-high reset
//   start_i             : DIV/DIVU in E, held across the stall
//   signed_div_i        : 1 = DIV, 0 = DIVU
//   opdata1_i/opdata2_i : dividend / divisor
//   annul_i             : exception flush, aborts the divide
//   result_o            : {remainder, quotient}, registered
//   ready_o             : one-cycle result-valid pulse, registered
module div_unit
  import div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);
  state_e      state_q;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvsr_q;
  logic [32:0] rem_sh, diff;
  logic [5:0]  cnt_q;
  logic        qneg_q, rneg_q, ready_q;
  logic [63:0] result_q;
  // rem_q stays below the divisor, so the 33rd remainder bit only exists in the shifted trial value
  always_comb begin
    rem_sh = {rem_q, quo_q[31]};
    diff   = rem_sh - {1'b0, dvsr_q};
    rem_d  = diff[32] ? rem_sh[31:0] : diff[31:0];
    quo_d  = {quo_q[30:0], ~diff[32]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b0;
      result_q <= 64'h0;
      cnt_q    <= 6'd0;
      rem_q    <= 32'h0;
      quo_q    <= 32'h0;
      dvsr_q   <= 32'h0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
    end else if (annul_i) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b0;
          if (start_i && opdata2_i == 32'h0) state_q <= S_DIVZERO;
          else if (start_i) begin
            rem_q   <= 32'h0;
            quo_q   <= neg_if(signed_div_i & opdata1_i[31], opdata1_i);
            dvsr_q  <= neg_if(signed_div_i & opdata2_i[31], opdata2_i);
            qneg_q  <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
            rneg_q  <= signed_div_i & opdata1_i[31];
            cnt_q   <= 6'd0;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_q  <= S_DONE;
            ready_q  <= 1'b1;
            result_q <= {neg_if(rneg_q, rem_d), neg_if(qneg_q, quo_d)};
          end
        end
        S_DIVZERO: begin
          state_q  <= S_DONE;
          ready_q  <= 1'b1;
          result_q <= 64'h0;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end
  assign result_o = result_q;
  assign ready_o  = ready_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst, start_i, signed_div_i, annul_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  int passed = 0;
  int total = 0;
  div_unit dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );
  always #5 clk = ~clk;
  task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b1;
    signed_div_i = s;
    opdata1_i = a;
    opdata2_i = b;
  endtask
  // returns the cycle (relative to the caller's current cycle) in which ready_o is first high, -1 on timeout
  task automatic wait_ready(input int limit, output int cyc);
    cyc = -1;
    for (int k = 1; k <= limit && cyc < 0; k++) begin
      @(posedge clk);
      #1;
      if (ready_o) cyc = k;
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    start_i = 1'b0;
    signed_div_i = 1'b0;
    annul_i = 1'b0;
    opdata1_i = 32'h0;
    opdata2_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (ready_o !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready_o); else passed++;
    total++;
    if (result_o !== 64'h0) $display("FAIL reset_result: got %h want 0", result_o); else passed++;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic test_divu;
    int c;
    start_op(1'b0, 32'd7, 32'd2);
    @(posedge clk);
    #1;
    opdata1_i = 32'hFFFF;
    opdata2_i = 32'h0;
    wait_ready(40, c);
    start_i = 1'b0;
    total++;
    if (c + 1 !== 33) $display("FAIL divu_latency: got cycle %0d want 33", c + 1); else passed++;
    total++;
    if (result_o !== {32'h1, 32'h3}) $display("FAIL divu_result: got %h want %h", result_o, {32'h1, 32'h3}); else passed++;
    @(posedge clk);
    #1;
    total++;
    if (ready_o !== 1'b0) $display("FAIL divu_single_pulse: got %b want 0", ready_o); else passed++;
  endtask
  task automatic test_signed;
    logic [31:0] a [3] = '{32'hFFFFFFF9, 32'h80000000, 32'h00000007};
    logic [31:0] b [3] = '{32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
    logic [63:0] e [3] = '{{32'hFFFFFFFF, 32'hFFFFFFFD}, {32'h0, 32'h80000000}, {32'h1, 32'hFFFFFFFD}};
    int c;
    for (int i = 0; i < 3; i++) begin
      start_op(1'b1, a[i], b[i]);
      wait_ready(40, c);
      start_i = 1'b0;
      total++;
      if (c !== 33) $display("FAIL div_latency_%0d: got cycle %0d want 33", i, c); else passed++;
      total++;
      if (result_o !== e[i]) $display("FAIL div_result_%0d: got %h want %h", i, result_o, e[i]); else passed++;
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_divzero;
    int c;
    for (int i = 0; i < 2; i++) begin
      start_op(i[0], i == 0 ? 32'd5 : 32'hFFFFFFFF, 32'h0);
      wait_ready(10, c);
      start_i = 1'b0;
      total++;
      if (c !== 2) $display("FAIL divzero_latency_%0d: got cycle %0d want 2", i, c); else passed++;
      total++;
      if (result_o !== 64'h0) $display("FAIL divzero_result_%0d: got %h want 0", i, result_o); else passed++;
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_back_to_back;
    int c;
    start_op(1'b0, 32'd100, 32'd7);
    wait_ready(40, c);
    opdata1_i = 32'd9;
    opdata2_i = 32'd3;
    total++;
    if (c !== 33) $display("FAIL b2b_first_latency: got cycle %0d want 33", c); else passed++;
    total++;
    if (result_o !== {32'd2, 32'd14}) $display("FAIL b2b_first_result: got %h want %h", result_o, {32'd2, 32'd14}); else passed++;
    wait_ready(40, c);
    start_i = 1'b0;
    total++;
    if (33 + c !== 67) $display("FAIL b2b_second_latency: got cycle %0d want 67", 33 + c); else passed++;
    total++;
    if (result_o !== {32'd0, 32'd3}) $display("FAIL b2b_second_result: got %h want %h", result_o, {32'd0, 32'd3}); else passed++;
    @(posedge clk);
    #1;
  endtask
  task automatic test_annul;
    int c;
    int pulses = 0;
    start_op(1'b0, 32'd100, 32'd7);
    for (int k = 1; k <= 11; k++) begin
      if (k == 10) annul_i = 1'b1;
      @(posedge clk);
      #1;
      if (ready_o) pulses++;
    end
    annul_i = 1'b0;
    opdata1_i = 32'd20;
    opdata2_i = 32'd6;
    total++;
    if (pulses !== 0) $display("FAIL annul_no_pulse: got %0d pulses want 0", pulses); else passed++;
    total++;
    if (result_o !== {32'd0, 32'd3}) $display("FAIL annul_result_kept: got %h want %h", result_o, {32'd0, 32'd3}); else passed++;
    wait_ready(40, c);
    start_i = 1'b0;
    total++;
    if (11 + c !== 44) $display("FAIL annul_restart_latency: got cycle %0d want 44", 11 + c); else passed++;
    total++;
    if (result_o !== {32'd2, 32'd3}) $display("FAIL annul_restart_result: got %h want %h", result_o, {32'd2, 32'd3}); else passed++;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset_mid;
    int c;
    start_op(1'b0, 32'd100, 32'd7);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_i = 1'b0;
    total++;
    if (ready_o !== 1'b0) $display("FAIL rst_mid_ready: got %b want 0", ready_o); else passed++;
    total++;
    if (result_o !== 64'h0) $display("FAIL rst_mid_result: got %h want 0", result_o); else passed++;
    wait_ready(40, c);
    total++;
    if (c !== -1) $display("FAIL rst_mid_no_pulse: got pulse in cycle %0d want none", c); else passed++;
  endtask
  initial begin
    test_reset;
    test_divu;
    test_signed;
    test_divzero;
    test_back_to_back;
    test_annul;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
